// File: rtl/tf_pkg.sv
// Shared constants and types for the Threefish-1024 key schedule.
// Optional ascending order support is compiled in with TF_KS_BIDIR_EN.
package tf_pkg;

  localparam logic [63:0] TF_C240   = 64'h1BD11BDAA9FC1A22;
  localparam int          TF_NW     = 16;
  localparam int          TF_NSUB   = 21;
  localparam int          TF_WORD_W = 64;
  localparam int          TF_IDX_W  = 5;

  typedef logic [TF_WORD_W-1:0] tf_word_t;
  typedef tf_word_t [TF_NW:0]   tf_ext_key_t;
  typedef tf_word_t [2:0]       tf_ext_tweak_t;
  typedef tf_word_t [TF_NW-1:0] tf_subkey_t;
  typedef logic [TF_IDX_W-1:0]  tf_idx_t;

  localparam tf_idx_t TF_LAST_IDX = tf_idx_t'(TF_NSUB - 1);

  typedef enum logic {
    ST_IDLE,
    ST_ACTIVE
  } tf_state_t;

  // Parity word k16: the constant folded with every key word.
  function automatic tf_word_t tf_key_parity(input logic [TF_NW*TF_WORD_W-1:0] key);
    tf_word_t acc;
    acc = TF_C240;
    for (int j = 0; j < TF_NW; j++) begin
      acc = acc ^ key[TF_WORD_W*j +: TF_WORD_W];
    end
    return acc;
  endfunction

endpackage

// File: rtl/tf_subkey_sel.sv
// Combinational subkey builder: picks key words by rotation and adds the
// tweak words and the subkey index into the upper three words.
module tf_subkey_sel
  import tf_pkg::*;
(
  input  tf_ext_key_t   ext_key,
  input  tf_ext_tweak_t ext_tweak,
  input  tf_idx_t       s,
  output tf_subkey_t    subkey
);

  tf_idx_t    s_m17;
  tf_idx_t    kidx;
  logic [1:0] t_sel0;
  logic [1:0] t_sel1;

  always_comb begin
    // NOTE: every variable gets a value before any branch so no latch is inferred.
    subkey = '0;
    kidx   = '0;
    // s never exceeds 20, so one subtraction reduces it mod 17; with i <= 15
    // the sum stays below 32 and again needs only one wrap.
    s_m17  = (s >= 5'd17) ? s - 5'd17 : s;
    t_sel0 = 2'(s % 5'd3);
    t_sel1 = (t_sel0 == 2'd2) ? 2'd0 : t_sel0 + 2'd1;
    for (int i = 0; i < TF_NW; i++) begin
      kidx = s_m17 + 5'(i);
      if (kidx >= 5'd17) kidx = kidx - 5'd17;
      subkey[i] = ext_key[kidx];
    end
    subkey[13] = subkey[13] + ext_tweak[t_sel0];
    subkey[14] = subkey[14] + ext_tweak[t_sel1];
    subkey[15] = subkey[15] + tf_word_t'(s);
  end

endmodule

// File: rtl/tf_key_scheduler_rev.sv
// Threefish-1024 subkey generator, descending order (s = 20..0) with a valid/next
// handshake. Define TF_KS_BIDIR_EN to add the dir port for ascending order.
module tf_key_scheduler_rev
  import tf_pkg::*;
(
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       load,
  input  logic [TF_NW*TF_WORD_W-1:0] key,
  input  logic [2*TF_WORD_W-1:0]     tweak,
`ifdef TF_KS_BIDIR_EN
  input  logic                       dir,
`endif
  input  logic                       next,
  output logic [TF_NW*TF_WORD_W-1:0] subkey,
  output logic [TF_IDX_W-1:0]        subkey_idx,
  output logic                       valid,
  output logic                       done
);

  tf_state_t     state_q,     state_d;
  tf_idx_t       idx_q,       idx_d;
  tf_ext_key_t   ext_key_q,   ext_key_d;
  tf_ext_tweak_t ext_tweak_q, ext_tweak_d;
  tf_subkey_t    subkey_q,    subkey_d;
  logic          done_q,      done_d;
  tf_subkey_t    sel_subkey;
  logic          descending;
  tf_idx_t       start_idx;
  tf_idx_t       end_idx;

`ifdef TF_KS_BIDIR_EN
  logic dir_q, dir_d;

  assign descending = dir_q;
  assign start_idx  = dir ? TF_LAST_IDX : '0;
  assign dir_d      = load ? dir : dir_q;
`else
  assign descending = 1'b1;
  assign start_idx  = TF_LAST_IDX;
`endif

  assign end_idx = descending ? '0 : TF_LAST_IDX;

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    ext_key_d   = ext_key_q;
    ext_tweak_d = ext_tweak_q;
    done_d      = 1'b0;
    if (load) begin
      ext_key_d[TF_NW-1:0] = key;
      ext_key_d[TF_NW]     = tf_key_parity(key);
      ext_tweak_d          = {tweak[127:64] ^ tweak[63:0], tweak};
      state_d              = ST_ACTIVE;
      idx_d                = start_idx;
    end else if (state_q == ST_ACTIVE && next) begin
      if (idx_q == end_idx) begin
        state_d = ST_IDLE;
        done_d  = 1'b1;
      end else begin
        idx_d = descending ? idx_q - 5'd1 : idx_q + 5'd1;
      end
    end
  end

  // The selector sees the post-edge key/index so the output register is
  // loaded with the subkey that becomes current, giving zero-bubble throughput.
  tf_subkey_sel u_subkey_sel (
    .ext_key   (ext_key_d),
    .ext_tweak (ext_tweak_d),
    .s         (idx_d),
    .subkey    (sel_subkey)
  );

  assign subkey_d = (state_d == ST_ACTIVE) ? sel_subkey : subkey_q;

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge value of every other flop.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      ext_key_q   <= '0;
      ext_tweak_q <= '0;
      subkey_q    <= '0;
      done_q      <= 1'b0;
`ifdef TF_KS_BIDIR_EN
      dir_q       <= 1'b1;
`endif
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      ext_key_q   <= ext_key_d;
      ext_tweak_q <= ext_tweak_d;
      subkey_q    <= subkey_d;
      done_q      <= done_d;
`ifdef TF_KS_BIDIR_EN
      dir_q       <= dir_d;
`endif
    end
  end

  assign subkey     = subkey_q;
  assign subkey_idx = idx_q;
  assign valid      = (state_q == ST_ACTIVE);
  assign done       = done_q;

endmodule
